// File: rtl/booth_mac_controller.sv
// booth_mac_controller
// Sequencer in front of an 8-bit Booth multiplier. Buffers signed operand
// pairs in a small FIFO and issues them one at a time over the multiplier's
// start/ready handshake. Each 16-bit product is sign-extended and added into
// a frame accumulator. When the frame's last pair has been captured, the sum
// and a sticky signed-overflow flag are offered downstream.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     operand stream handshake (in_ready = FIFO not full)
//   in_a, in_b, in_last   signed multiplicand, signed multiplier, frame end
//   mul_m, mul_r          registered operands to the multiplier
//   mul_start             one-cycle start pulse to the multiplier
//   mul_ready, mul_ans    multiplier idle flag and signed 16-bit product
//   out_valid/out_ready   frame result handshake
//   acc_out, acc_ovf      live signed accumulator and sticky overflow flag
module booth_mac_controller #(
    parameter int DEPTH = 4,
    parameter int ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_m,
    output logic [7:0]       mul_r,
    output logic             mul_start,
    input  logic             mul_ready,
    input  logic [15:0]      mul_ans,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [16:0]             fifo_mem_q [DEPTH];
    logic [16:0]             fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [7:0]              mul_m_q, mul_m_d;
    logic [7:0]              mul_r_q, mul_r_d;
    logic                    last_q, last_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum;
    logic                    push;
    logic                    pop;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic [15:0] p);
        return ACC_W'($signed(p));
    endfunction

    // Two's-complement overflow: equal-sign addends whose sum flips sign.
    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b,
                                     input logic signed [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never opens room for that cycle's push.
    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    // The mul_ready gate also keeps us from reissuing after a reset while
    // the multiplier is still finishing an abandoned product.
    assign pop      = (state_q == IDLE) && (count_q != '0) && mul_ready;

    // Operand FIFO
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {in_last, in_a, in_b};
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Issue / accumulate sequencer
    always_comb begin
        state_d   = state_q;
        mul_m_d   = mul_m_q;
        mul_r_d   = mul_r_q;
        last_d    = last_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        out_valid = 1'b0;
        prod_ext  = sext_prod(mul_ans);
        sum       = acc_q + prod_ext;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    {last_d, mul_m_d, mul_r_d} = fifo_mem_q[rd_ptr_q];
                    state_d                    = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_d   = WAIT_LO;
            end
            WAIT_LO: begin
                // No timeout: a stalled multiplier simply holds us here.
                if (!mul_ready) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (mul_ready) begin
                    acc_d   = sum;
                    ovf_d   = ovf_q | add_ovf(acc_q, prod_ext, sum);
                    state_d = last_q ? DONE : IDLE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mul_m_q  <= '0;
            mul_r_q  <= '0;
            last_q   <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mul_m_q  <= mul_m_d;
            mul_r_q  <= mul_r_d;
            last_q   <= last_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage is pure data; the count and pointers say what is valid.
    always_ff @(posedge clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign mul_m   = mul_m_q;
    assign mul_r   = mul_r_q;
    assign acc_out = acc_q;
    assign acc_ovf = ovf_q;

endmodule

// File: tb/tb_booth_mac_controller.sv
module tb_booth_mac_controller;
    localparam int DEPTH = 4;
    localparam int ACC_W = 20;
    localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));
    localparam longint ACC_MOD = longint'(1) << ACC_W;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_a = '0;
    logic [7:0]       in_b = '0;
    logic             in_last = 1'b0;
    logic [7:0]       mul_m;
    logic [7:0]       mul_r;
    logic             mul_start;
    logic             mul_ready = 1'b1;
    logic [15:0]      mul_ans = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] acc_out;
    logic             acc_ovf;

    int n_chk = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int frames_done = 0;
    int mul_lat = 10;
    logic hold = 1'b0;
    logic [ACC_W-1:0] last_acc = '0;
    logic last_ovf = 1'b0;

    // reference model / multiplier model state
    exp_t        exp_q[$];
    logic [15:0] iss_q[$];
    longint      fsum = 0;
    logic        fovf = 1'b0;
    int          busy = 0;
    logic [7:0]  cap_m = '0;
    logic [7:0]  cap_r = '0;
    logic        unstable = 1'b0;
    logic        abandon = 1'b0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        prst = 1'b1;
    logic [ACC_W-1:0] pacc = '0;
    logic        povf = 1'b0;
    exp_t        e;

    booth_mac_controller #(.DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_m     (mul_m),
        .mul_r     (mul_r),
        .mul_start (mul_start),
        .mul_ready (mul_ready),
        .mul_ans   (mul_ans),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .acc_ovf   (acc_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input int a, input int b, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_accept_timeout", in_ready, 1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            tick(1);
            n++;
        end
        check("frame_done_in_time", longint'(frames_done >= target), 1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!out_valid && n < budget) begin
            tick(1);
            n++;
        end
        check("out_valid_rises", out_valid, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_mul_start"}, mul_start, 0);
        check({tag, "_mul_m"}, mul_m, 0);
        check({tag, "_mul_r"}, mul_r, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_acc_out"}, acc_out, 0);
        check({tag, "_acc_ovf"}, acc_ovf, 0);
    endtask

    // Monitor: multiplier model, reference model and result scoreboard.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (pv && !prst) begin
                if (pr) begin
                    check("out_valid_drop", out_valid, 0);
                end else begin
                    check("out_valid_hold", out_valid, 1);
                    check("acc_out_hold", acc_out, pacc);
                    check("acc_ovf_hold", acc_ovf, povf);
                end
            end
            if (rst) begin
                fsum = 0;
                fovf = 1'b0;
                exp_q.delete();
                iss_q.delete();
                abandon = 1'b1;
            end
            if (mul_start) begin
                start_cnt++;
                check("start_while_busy", busy, 0);
                check("issue_pending", longint'(iss_q.size() != 0), 1);
                if (iss_q.size() != 0) begin
                    check("issue_operands", {mul_m, mul_r}, iss_q.pop_front());
                end
                cap_m    = mul_m;
                cap_r    = mul_r;
                busy     = mul_lat;
                unstable = 1'b0;
                abandon  = 1'b0;
            end else if (busy > 0) begin
                if (mul_m != cap_m || mul_r != cap_r) unstable = 1'b1;
                busy--;
                if (busy == 0) begin
                    mul_ans = 16'(int'($signed(cap_m)) * int'($signed(cap_r)));
                    if (!abandon) check("operands_stable", unstable, 0);
                end
            end
            mul_ready = (busy == 0) && !hold;
            if (!rst && in_valid && in_ready) begin
                iss_q.push_back({in_a, in_b});
                fsum = fsum + longint'($signed(in_a)) * longint'($signed(in_b));
                if (fsum > ACC_MAX) begin
                    fsum = fsum - ACC_MOD;
                    fovf = 1'b1;
                end else if (fsum < ACC_MIN) begin
                    fsum = fsum + ACC_MOD;
                    fovf = 1'b1;
                end
                if (in_last) begin
                    exp_q.push_back('{acc: ACC_W'(fsum), ovf: fovf});
                    fsum = 0;
                    fovf = 1'b0;
                end
            end
            if (!rst && out_valid && out_ready) begin
                check("result_pending", longint'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("acc_out", acc_out, e.acc);
                    check("acc_ovf", acc_ovf, e.ovf);
                end
                last_acc = acc_out;
                last_ovf = acc_ovf;
                frames_done++;
            end
            pv   = out_valid;
            pr   = out_ready;
            prst = rst;
            pacc = acc_out;
            povf = acc_ovf;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, summary not yet printed");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int s0;
        int s1;
        int base;
        int n;
        int len;

        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Small mixed-sign frame
        s0 = start_cnt;
        push_pair(3, 4, 1'b0);
        push_pair(-5, 6, 1'b1);
        wait_frames(1, 200);
        check("t1_acc", last_acc, 20'hFFFEE);
        check("t1_ovf", last_ovf, 0);
        check("t1_start_pulses", start_cnt - s0, 2);

        // Largest positive product
        push_pair(-128, -128, 1'b1);
        wait_frames(2, 200);
        check("t2_acc", last_acc, 20'h04000);
        check("t2_ovf", last_ovf, 0);

        // Accumulator overflow, then flag cleared for the next frame
        for (int i = 1; i <= 32; i++) push_pair(-128, -128, i == 32);
        wait_frames(3, 300);
        check("t3_acc", last_acc, 20'h80000);
        check("t3_ovf", last_ovf, 1);
        push_pair(1, 1, 1'b1);
        wait_frames(4, 200);
        check("t3b_acc", last_acc, 20'h00001);
        check("t3b_ovf", last_ovf, 0);

        // Random frames with random multiplier latency and gaps
        for (int f = 0; f < 6; f++) begin
            len = int'($urandom_range(1, 5));
            for (int k = 0; k < len; k++) begin
                mul_lat = int'($urandom_range(2, 12));
                push_pair(int'($urandom_range(0, 255)) - 128,
                          int'($urandom_range(0, 255)) - 128, k == len - 1);
                tick(int'($urandom_range(0, 3)));
            end
        end
        wait_frames(10, 500);
        mul_lat = 10;

        // Back-pressure: FIFO fill, frame held in DONE, then drain in order
        base = frames_done;
        hold = 1'b1;
        tick(2);
        out_ready = 1'b0;
        push_pair(2, 3, 1'b0);
        push_pair(4, 5, 1'b1);
        push_pair(-6, 7, 1'b0);
        check("t4_in_ready_before_full", in_ready, 1);
        push_pair(8, -9, 1'b0);
        check("t4_in_ready_full", in_ready, 0);
        fork
            begin
                tick(3);
                hold = 1'b0;
            end
            begin
                push_pair(10, 11, 1'b0);
                push_pair(-12, -13, 1'b1);
            end
        join
        wait_valid(300);
        s0 = start_cnt;
        tick(50);
        check("t4_valid_held", out_valid, 1);
        check("t4_no_start_in_done", start_cnt, s0);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("t4_frame_a_taken", frames_done, base + 1);
        tick(2);
        wait_valid(300);
        out_ready = 1'b1;
        wait_frames(base + 2, 50);

        // Stalled multiplier
        base = frames_done;
        mul_lat = 40;
        s0 = start_cnt;
        push_pair(-7, 11, 1'b1);
        wait_frames(base + 1, 200);
        check("t5_single_start", start_cnt - s0, 1);
        mul_lat = 10;

        // Reset mid-operation with queued pairs and a busy multiplier
        base = frames_done;
        mul_lat = 30;
        s0 = start_cnt;
        push_pair(7, 9, 1'b0);
        push_pair(1, 2, 1'b0);
        push_pair(3, 4, 1'b0);
        push_pair(5, 6, 1'b0);
        push_pair(-1, -1, 1'b1);
        n = 0;
        while (start_cnt < s0 + 2 && n < 400) begin
            tick(1);
            n++;
        end
        check("t6_second_issue", start_cnt, s0 + 2);
        check("t6_acc_before_rst", acc_out, 63);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        mul_lat = 10;
        s1 = start_cnt;
        push_pair(5, 5, 1'b1);
        tick(5);
        check("t6_no_start_while_busy", start_cnt, s1);
        wait_frames(base + 1, 200);
        check("t6_acc_after_rst", last_acc, 25);

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
